pipe_hazard_ctrl: RTL

Pipeline sequencing controller for the 5-stage MIPS core. It sits beside the forwarding unit and drives the stage-register enables and bubble/flush controls.
- Stalls on load-use hazards that forwarding cannot cover.
- Freezes the front of the pipe while a multi-cycle mult/div occupies EX.
- Flushes wrong-path instructions on a taken branch resolved in EX.
- Counts stall cycles for performance debug.

---
 rtl/pipe_hazard_ctrl.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline sequencing controller: load-use stall, mult/div freeze,
// taken-branch flush and a saturating stall-cycle counter.
module pipe_hazard_ctrl #(
    parameter int MULDIV_LAT = 4,
    parameter int CNT_W      = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             IDEX_MemRead,
    input  logic [4:0]       IDEX_Rt,
    input  logic             IDEX_MulDiv,
    input  logic [4:0]       IFID_Rs,
    input  logic [4:0]       IFID_Rt,
    input  logic             IFID_UsesRt,
    input  logic             Branch_Taken,
    output logic             PCWrite,
    output logic             IFIDWrite,
    output logic             IDEXWrite,
    output logic             IFID_Flush,
    output logic             IDEX_Bubble,
    output logic             EXMEM_Bubble,
    output logic             MulDiv_Busy,
    output logic             MulDiv_Done,
    output logic [CNT_W-1:0] StallCount
);

    localparam int CW = $clog2(MULDIV_LAT) + 1;
    localparam int INIT = (MULDIV_LAT > 1) ? (MULDIV_LAT - 2) : 0;
    localparam logic [CW-1:0] CNT_INIT = CW'(INIT);
    localparam logic MULTI = (MULDIV_LAT > 1);

    typedef enum logic {
        RUN,
        MULDIV
    } state_t;

    state_t        state;
    state_t        state_nxt;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nxt;
    logic          freeze;
    logic          done;
    logic          load_use;

    always_ff @(posedge clk) begin
        if (rst) begin
            state <= RUN;
            cnt   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
        end
    end

    // IDEX_MulDiv is only looked at in RUN, so one op never re-triggers
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        unique case (state)
            RUN: begin
                if (IDEX_MulDiv && MULTI) begin
                    state_nxt = MULDIV;
                    cnt_nxt   = CNT_INIT;
                end
            end
            MULDIV: begin
                if (cnt != '0) begin
                    cnt_nxt = cnt - 1'b1;
                end else begin
                    state_nxt = RUN;
                end
            end
            default: begin
                state_nxt = RUN;
                cnt_nxt   = '0;
            end
        endcase
    end

    always_comb begin
        freeze = 1'b0;
        done   = 1'b0;
        unique case (state)
            RUN: begin
                freeze = IDEX_MulDiv && MULTI;
                done   = IDEX_MulDiv && !MULTI;
            end
            MULDIV: begin
                freeze = (cnt != '0);
                done   = (cnt == '0);
            end
            default: begin
                freeze = 1'b0;
                done   = 1'b0;
            end
        endcase
    end

    always_comb begin
        load_use = IDEX_MemRead && (IDEX_Rt != 5'd0) &&
                   ((IDEX_Rt == IFID_Rs) ||
                    (IFID_UsesRt && (IDEX_Rt == IFID_Rt)));
    end

    // Branch beats load-use: the ID instruction is on the wrong path
    always_comb begin
        PCWrite      = 1'b1;
        IFIDWrite    = 1'b1;
        IDEXWrite    = 1'b1;
        IFID_Flush   = 1'b0;
        IDEX_Bubble  = 1'b0;
        EXMEM_Bubble = 1'b0;
        MulDiv_Busy  = 1'b0;
        MulDiv_Done  = 1'b0;
        if (!rst) begin
            MulDiv_Done = done;
            if (freeze) begin
                PCWrite      = 1'b0;
                IFIDWrite    = 1'b0;
                IDEXWrite    = 1'b0;
                EXMEM_Bubble = 1'b1;
                MulDiv_Busy  = 1'b1;
            end else if (Branch_Taken) begin
                IFID_Flush  = 1'b1;
                IDEX_Bubble = 1'b1;
            end else if (load_use) begin
                PCWrite     = 1'b0;
                IFIDWrite   = 1'b0;
                IDEX_Bubble = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            StallCount <= '0;
        end else if (!PCWrite && (StallCount != '1)) begin
            StallCount <= StallCount + CNT_W'(1);
        end
    end

endmodule
